// File: rtl/slow_clock_monitor.sv
// Slow-clock health monitor: synchronises clk_in, measures edge-to-edge intervals in clk_50MHz cycles,
// flags tolerance and stuck input. Define MONITOR_RISING_ONLY_EN to measure full periods (rising edges only).
module slow_clock_monitor #(
  parameter int unsigned CNT_W    = 26,
  parameter int unsigned EXP_HALF = 25_000_001,
  parameter int unsigned TOL      = 1000,
  parameter int unsigned TIMEOUT  = 60_000_000
) (
  input  logic             clk_50MHz,
  input  logic             reset,
  input  logic             clk_in,
  output logic             edge_tick,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_valid,
  output logic             in_range,
  output logic             stuck
);

  localparam int unsigned MW = CNT_W + 1;
`ifdef MONITOR_RISING_ONLY_EN
  localparam int unsigned EXP_CNT = 2 * EXP_HALF;
`else
  localparam int unsigned EXP_CNT = EXP_HALF;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_STUCK = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             edge_tick_q, edge_tick_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             meas_valid_q, meas_valid_d;
  logic             in_range_q, in_range_d;
  logic             stuck_q, stuck_d;

  logic             edge_c;
  logic             timeout_c;
  logic [MW-1:0]    meas_c;
  logic [MW-1:0]    dev_c;
  logic             ok_c;

  // Synchroniser, edge qualification and interval arithmetic
  always_comb begin
    s1_d   = clk_in;
    s2_d   = s1_q;
    prev_d = s2_q;
`ifdef MONITOR_RISING_ONLY_EN
    edge_c = s2_q & ~prev_q;
`else
    edge_c = s2_q ^ prev_q;
`endif
    meas_c    = {1'b0, cnt_q} + MW'(1);
    dev_c     = (meas_c >= MW'(EXP_CNT)) ? (meas_c - MW'(EXP_CNT)) : (MW'(EXP_CNT) - meas_c);
    ok_c      = (dev_c <= MW'(TOL));
    // Fires on the cycle the counter is about to reach TIMEOUT
    timeout_c = (cnt_q == CNT_W'(TIMEOUT - 1));

    if (edge_c) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(TIMEOUT)) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Next-state and registered-output logic; an edge always takes priority over timeout
  always_comb begin
    state_d      = state_q;
    period_d     = period_q;
    meas_valid_d = 1'b0;
    in_range_d   = in_range_q;
    edge_tick_d  = edge_c;

    case (state_q)
      ST_IDLE: begin
        if (edge_c) begin
          state_d = ST_ARMED;
        end else if (timeout_c) begin
          state_d    = ST_STUCK;
          in_range_d = 1'b0;
        end
      end
      ST_ARMED: begin
        if (edge_c) begin
          period_d     = meas_c[CNT_W-1:0];
          meas_valid_d = 1'b1;
          in_range_d   = ok_c;
        end else if (timeout_c) begin
          state_d    = ST_STUCK;
          in_range_d = 1'b0;
        end
      end
      ST_STUCK: begin
        // Interval since recovery edge is partial, so no measurement here
        if (edge_c) begin
          state_d = ST_ARMED;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    stuck_d = (state_d == ST_STUCK);
  end

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      prev_q       <= 1'b0;
      cnt_q        <= '0;
      edge_tick_q  <= 1'b0;
      period_q     <= '0;
      meas_valid_q <= 1'b0;
      in_range_q   <= 1'b0;
      stuck_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      prev_q       <= prev_d;
      cnt_q        <= cnt_d;
      edge_tick_q  <= edge_tick_d;
      period_q     <= period_d;
      meas_valid_q <= meas_valid_d;
      in_range_q   <= in_range_d;
      stuck_q      <= stuck_d;
    end
  end

  assign edge_tick  = edge_tick_q;
  assign period_cnt = period_q;
  assign meas_valid = meas_valid_q;
  assign in_range   = in_range_q;
  assign stuck      = stuck_q;

endmodule

// File: tb/tb_slow_clock_monitor.sv
// Directed bench for slow_clock_monitor with CNT_W=8, EXP_HALF=10, TOL=1, TIMEOUT=30.
module tb_slow_clock_monitor;

  logic       clk_50MHz;
  logic       reset;
  logic       clk_in;
  logic       edge_tick;
  logic [7:0] period_cnt;
  logic       meas_valid;
  logic       in_range;
  logic       stuck;

  int chk_cnt;
  int pass_cnt;

  slow_clock_monitor #(
    .CNT_W   (8),
    .EXP_HALF(10),
    .TOL     (1),
    .TIMEOUT (30)
  ) dut (
    .clk_50MHz (clk_50MHz),
    .reset     (reset),
    .clk_in    (clk_in),
    .edge_tick (edge_tick),
    .period_cnt(period_cnt),
    .meas_valid(meas_valid),
    .in_range  (in_range),
    .stuck     (stuck)
  );

  initial clk_50MHz = 1'b0;
  always #10 clk_50MHz = ~clk_50MHz;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_50MHz);
      #1;
    end
  endtask

  task automatic apply_reset();
    clk_in = 1'b0;
    reset  = 1'b1;
    step(3);
    reset  = 1'b0;
  endtask

  // Toggle clk_in, check the synchronised edge 3 cycles later, then idle until hold cycles have elapsed
  task automatic toggle_edge(input string name, input bit exp_tick, input bit exp_meas,
                             input int exp_period, input bit exp_range, input int hold);
    clk_in = ~clk_in;
    step(2);
    chk_cnt++;
    if (edge_tick !== 1'b0) $display("FAIL %s early edge_tick got %0b exp 0", name, edge_tick);
    else pass_cnt++;
    step(1);
    chk_cnt++;
    if (edge_tick !== exp_tick) $display("FAIL %s edge_tick got %0b exp %0b", name, edge_tick, exp_tick);
    else pass_cnt++;
    chk_cnt++;
    if (meas_valid !== exp_meas) $display("FAIL %s meas_valid got %0b exp %0b", name, meas_valid, exp_meas);
    else pass_cnt++;
    chk_cnt++;
    if (stuck !== 1'b0) $display("FAIL %s stuck got %0b exp 0", name, stuck);
    else pass_cnt++;
    if (exp_meas) begin
      chk_cnt++;
      if (period_cnt !== 8'(exp_period))
        $display("FAIL %s period_cnt got %0d exp %0d", name, period_cnt, exp_period);
      else pass_cnt++;
      chk_cnt++;
      if (in_range !== exp_range) $display("FAIL %s in_range got %0b exp %0b", name, in_range, exp_range);
      else pass_cnt++;
    end
    step(hold - 3);
  endtask

  task automatic test_reset();
    clk_in = 1'b0;
    reset  = 1'b1;
    step(2);
    chk_cnt++;
    if ({edge_tick, meas_valid, in_range, stuck, period_cnt} !== 12'h000)
      $display("FAIL reset_outputs got %03h exp 000", {edge_tick, meas_valid, in_range, stuck, period_cnt});
    else pass_cnt++;
    reset = 1'b0;
    step(29);
    chk_cnt++;
    if ({edge_tick, meas_valid, in_range, stuck, period_cnt} !== 12'h000)
      $display("FAIL idle_29 got %03h exp 000", {edge_tick, meas_valid, in_range, stuck, period_cnt});
    else pass_cnt++;
    step(1);
    chk_cnt++;
    if (stuck !== 1'b1) $display("FAIL idle_timeout stuck got %0b exp 1", stuck);
    else pass_cnt++;
    chk_cnt++;
    if (in_range !== 1'b0 || period_cnt !== 8'd0)
      $display("FAIL idle_timeout in_range/period got %0b/%0d exp 0/0", in_range, period_cnt);
    else pass_cnt++;
  endtask

`ifndef MONITOR_RISING_ONLY_EN
  task automatic test_toggle10();
    apply_reset();
    toggle_edge("t10_first", 1'b1, 1'b0, 0, 1'b0, 10);
    for (int k = 0; k < 3; k++) toggle_edge("t10", 1'b1, 1'b1, 10, 1'b1, 10);
  endtask

  task automatic test_intervals();
    apply_reset();
    toggle_edge("iv_first", 1'b1, 1'b0, 0, 1'b0, 9);
    toggle_edge("iv_9", 1'b1, 1'b1, 9, 1'b1, 11);
    toggle_edge("iv_11", 1'b1, 1'b1, 11, 1'b1, 12);
    toggle_edge("iv_12", 1'b1, 1'b1, 12, 1'b0, 8);
    toggle_edge("iv_8", 1'b1, 1'b1, 8, 1'b0, 10);
    toggle_edge("iv_10", 1'b1, 1'b1, 10, 1'b1, 10);
  endtask

  task automatic test_stuck();
    apply_reset();
    toggle_edge("st_first", 1'b1, 1'b0, 0, 1'b0, 10);
    toggle_edge("st_pre", 1'b1, 1'b1, 10, 1'b1, 3);
    step(29);
    chk_cnt++;
    if (stuck !== 1'b0) $display("FAIL st_29 stuck got %0b exp 0", stuck);
    else pass_cnt++;
    step(1);
    chk_cnt++;
    if (stuck !== 1'b1) $display("FAIL st_30 stuck got %0b exp 1", stuck);
    else pass_cnt++;
    chk_cnt++;
    if (in_range !== 1'b0) $display("FAIL st_30 in_range got %0b exp 0", in_range);
    else pass_cnt++;
    chk_cnt++;
    if (period_cnt !== 8'd10) $display("FAIL st_30 period_cnt got %0d exp 10", period_cnt);
    else pass_cnt++;
    step(5);
    toggle_edge("st_recover", 1'b1, 1'b0, 0, 1'b0, 10);
    toggle_edge("st_after", 1'b1, 1'b1, 10, 1'b1, 10);
  endtask

  task automatic test_edge_vs_timeout();
    apply_reset();
    toggle_edge("evt_first", 1'b1, 1'b0, 0, 1'b0, 10);
    toggle_edge("evt_pre", 1'b1, 1'b1, 10, 1'b1, 30);
    toggle_edge("evt_30", 1'b1, 1'b1, 30, 1'b0, 10);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    toggle_edge("rm_first", 1'b1, 1'b0, 0, 1'b0, 10);
    toggle_edge("rm_pre", 1'b1, 1'b1, 10, 1'b1, 5);
    reset = 1'b1;
    #1;
    chk_cnt++;
    if ({edge_tick, meas_valid, in_range, stuck, period_cnt} !== 12'h000)
      $display("FAIL rm_async got %03h exp 000", {edge_tick, meas_valid, in_range, stuck, period_cnt});
    else pass_cnt++;
    step(2);
    reset = 1'b0;
    step(3);
    toggle_edge("rm_post_first", 1'b1, 1'b0, 0, 1'b0, 10);
    toggle_edge("rm_post", 1'b1, 1'b1, 10, 1'b1, 10);
  endtask
`else
  task automatic test_rising_only();
    apply_reset();
    toggle_edge("ro_rise0", 1'b1, 1'b0, 0, 1'b0, 10);
    toggle_edge("ro_fall0", 1'b0, 1'b0, 0, 1'b0, 10);
    toggle_edge("ro_rise1", 1'b1, 1'b1, 20, 1'b1, 10);
    toggle_edge("ro_fall1", 1'b0, 1'b0, 0, 1'b0, 10);
    toggle_edge("ro_rise2", 1'b1, 1'b1, 20, 1'b1, 10);
  endtask
`endif

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    reset    = 1'b1;
    clk_in   = 1'b0;
    test_reset();
`ifndef MONITOR_RISING_ONLY_EN
    test_toggle10();
    test_intervals();
    test_stuck();
    test_edge_vs_timeout();
    test_reset_mid();
`else
    test_rising_only();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
